// File: rtl/alu_seq_if.sv
// Issue/result bundle for alu_seq: request fields flow master->slave, results and flags flow back.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] value;
    logic [WIDTH-1:0] value_hi;
    logic             carry;
    logic             zeroflag;
    logic             msb;
    logic             overflow;

    modport master (
        output start, op, x, y,
        input  busy, done, value, value_hi, carry, zeroflag, msb, overflow
    );

    modport slave (
        input  start, op, x, y,
        output busy, done, value, value_hi, carry, zeroflag, msb, overflow
    );
endinterface

// File: rtl/alu_seq.sv
// Registered execute-stage ALU: single-cycle add/sub/logic/shift, iterative unsigned MUL and,
// when ALU_DIV_EN is defined, an iterative restoring DIV (otherwise op 11 is an undefined op).
//
// state | meaning
// IDLE  | accepts start; single-cycle ops complete here and pulse done
// ITER  | one MUL/DIV iteration per clock; the WIDTH-th iteration writes results and returns to IDLE
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_NOT = 4'd6;
    localparam logic [3:0] OP_SLL = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SRA = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;
`ifdef ALU_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd11;
`endif

    typedef enum logic {IDLE, ITER} state_t;

    state_t           state, state_nx;
    logic             load_iter, fin_single, fin_iter, is_iter_op;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] opy, hi, lo;
    logic [WIDTH-1:0] it_hi, it_lo;
    logic [WIDTH-1:0] s_res;
    logic             s_carry, s_ovf;
    logic [SHW-1:0]   amt;
    logic [WIDTH:0]   add_w, sub_w, sll_w, srl_w, sra_w;
    logic [WIDTH:0]   mul_sum;
`ifdef ALU_DIV_EN
    logic             is_div;
    logic [WIDTH:0]   div_sh, div_rem;
    logic             div_ge;
`endif

    always_comb begin
        is_iter_op = (bus.op == OP_MUL);
`ifdef ALU_DIV_EN
        if (bus.op == OP_DIV) is_iter_op = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load_iter  = 1'b0;
        fin_single = 1'b0;
        fin_iter   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (is_iter_op) begin
                        load_iter = 1'b1;
                        state_nx  = ITER;
                    end else begin
                        fin_single = 1'b1;
                    end
                end
            end
            ITER: begin
                if (cnt == CNT_LAST) begin
                    fin_iter = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.busy = (state == ITER);

    // Shifts run one bit wider so the last bit shifted out lands in the extra position.
    always_comb begin
        amt   = bus.y[SHW-1:0];
        add_w = {1'b0, bus.x} + {1'b0, bus.y};
        sub_w = {1'b0, bus.x} + {1'b0, ~bus.y} + (WIDTH+1)'(1);
        sll_w = {1'b0, bus.x} << amt;
        srl_w = {bus.x, 1'b0} >> amt;
        sra_w = $signed({bus.x, 1'b0}) >>> amt;

        s_res   = '0;
        s_carry = 1'b0;
        s_ovf   = 1'b0;
        case (bus.op)
            OP_ADD: begin
                s_res   = add_w[WIDTH-1:0];
                s_carry = add_w[WIDTH];
                s_ovf   = (bus.x[WIDTH-1] == bus.y[WIDTH-1]) && (add_w[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_SUB: begin
                s_res   = sub_w[WIDTH-1:0];
                s_carry = sub_w[WIDTH];
                s_ovf   = (bus.x[WIDTH-1] != bus.y[WIDTH-1]) && (sub_w[WIDTH-1] != bus.x[WIDTH-1]);
            end
            OP_AND: s_res = bus.x & bus.y;
            OP_OR:  s_res = bus.x | bus.y;
            OP_XOR: s_res = bus.x ^ bus.y;
            OP_NOR: s_res = ~(bus.x | bus.y);
            OP_NOT: s_res = ~bus.x;
            OP_SLL: begin
                s_res   = sll_w[WIDTH-1:0];
                s_carry = sll_w[WIDTH];
            end
            OP_SRL: begin
                s_res   = srl_w[WIDTH:1];
                s_carry = srl_w[0];
            end
            OP_SRA: begin
                s_res   = sra_w[WIDTH:1];
                s_carry = sra_w[0];
            end
            default: ;
        endcase
    end

    // One iteration step: {hi,lo} is the product shift register or remainder/quotient pair.
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opy} : '0);
        it_hi   = mul_sum[WIDTH:1];
        it_lo   = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        div_sh  = {hi, lo[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opy});
        div_rem = div_ge ? (div_sh - {1'b0, opy}) : div_sh;
        if (is_div) begin
            it_hi = div_rem[WIDTH-1:0];
            it_lo = {lo[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            opy          <= '0;
            hi           <= '0;
            lo           <= '0;
`ifdef ALU_DIV_EN
            is_div       <= 1'b0;
`endif
            bus.done     <= 1'b0;
            bus.value    <= '0;
            bus.value_hi <= '0;
            bus.carry    <= 1'b0;
            bus.zeroflag <= 1'b0;
            bus.msb      <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (load_iter) begin
                cnt <= '0;
                hi  <= '0;
                lo  <= bus.x;
                opy <= bus.y;
`ifdef ALU_DIV_EN
                is_div <= (bus.op == OP_DIV);
`endif
            end
            if (state == ITER) begin
                cnt <= cnt + SHW'(1);
                hi  <= it_hi;
                lo  <= it_lo;
            end
            if (fin_single) begin
                bus.done     <= 1'b1;
                bus.value    <= s_res;
                bus.value_hi <= '0;
                bus.carry    <= s_carry;
                bus.zeroflag <= (s_res == '0);
                bus.msb      <= s_res[WIDTH-1];
                bus.overflow <= s_ovf;
            end
            if (fin_iter) begin
                bus.done     <= 1'b1;
                bus.value    <= it_lo;
                bus.value_hi <= it_hi;
                bus.carry    <= |it_hi;
`ifdef ALU_DIV_EN
                if (is_div) bus.carry <= (opy == '0);
`endif
                bus.zeroflag <= (it_lo == '0);
                bus.msb      <= it_lo[WIDTH-1];
                bus.overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); DIV vectors run when ALU_DIV_EN is defined.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n, busy_cnt, done_seen;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(32)) bus();
    alu_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {carry, zeroflag, msb, overflow}
    function automatic logic [3:0] flags();
        return {bus.carry, bus.zeroflag, bus.msb, bus.overflow};
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = o; bus.x = a; bus.y = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.x = 32'hA5A5_5A5A; bus.y = 32'h0F0F_F0F0; bus.op = 4'd15;
    endtask

    task automatic wait_done(input int max, output int cnt);
        cnt = -1;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 4'd0; bus.x = '0; bus.y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_value", bus.value, 32'h0);
        chk("rst_value_hi", bus.value_hi, 32'h0);
        chk("rst_flags", flags(), 4'b0000);
        @(negedge clk); rst = 1'b0;

        issue(4'd0, 32'd10, 32'd11);
        chk("add_done", bus.done, 1'b1);
        chk("add_value", bus.value, 32'd21);
        chk("add_flags", flags(), 4'b0000);
        @(posedge clk); #1;
        chk("add_done_drop", bus.done, 1'b0);
        chk("add_value_hold", bus.value, 32'd21);

        issue(4'd1, 32'd0, 32'd2);
        chk("sub_neg_value", bus.value, 32'hFFFF_FFFE);
        chk("sub_neg_flags", flags(), 4'b0010);
        issue(4'd1, 32'd2, 32'd2);
        chk("sub_zero_value", bus.value, 32'h0);
        chk("sub_zero_flags", flags(), 4'b1100);
        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_value", bus.value, 32'h8000_0000);
        chk("add_ovf_flags", flags(), 4'b0011);

        issue(4'd9, 32'h8000_0001, 32'd1);
        chk("sra_value", bus.value, 32'hC000_0000);
        chk("sra_flags", flags(), 4'b1010);
        issue(4'd7, 32'h1234_5678, 32'd32);
        chk("sll0_value", bus.value, 32'h1234_5678);
        chk("sll0_flags", flags(), 4'b0000);
        issue(4'd8, 32'h8000_000F, 32'd4);
        chk("srl_value", bus.value, 32'h0800_0000);
        chk("srl_flags", flags(), 4'b1000);
        issue(4'd5, 32'h0000_00F0, 32'h0000_000F);
        chk("nor_value", bus.value, 32'hFFFF_FF00);
        issue(4'd6, 32'h0, 32'h1234);
        chk("not_value", bus.value, 32'hFFFF_FFFF);
        chk("not_hi", bus.value_hi, 32'h0);

        // MUL with an ignored start in mid-flight
        issue(4'd10, 32'hFFFF_FFFF, 32'd2);
        chk("mul_busy_e", bus.busy, 1'b1);
        chk("mul_done_e", bus.done, 1'b0);
        busy_cnt = 1;
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            if (i == 5) begin
                bus.start = 1'b1; bus.op = 4'd0; bus.x = 32'd1; bus.y = 32'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done) begin
                n = i;
                break;
            end
            if (bus.busy) busy_cnt++;
        end
        chk("mul_latency", n, 32);
        chk("mul_busy_cycles", busy_cnt, 32);
        chk("mul_busy_at_done", bus.busy, 1'b0);
        chk("mul_value", bus.value, 32'hFFFF_FFFE);
        chk("mul_value_hi", bus.value_hi, 32'h1);
        chk("mul_flags", flags(), 4'b1010);

        // back-to-back MUL issued on the done cycle
        bus.start = 1'b1; bus.op = 4'd10; bus.x = 32'd3; bus.y = 32'd5;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.x = 32'hFFFF_FFFF; bus.y = 32'hFFFF_FFFF;
        chk("mul2_accepted", bus.busy, 1'b1);
        chk("mul2_done_low", bus.done, 1'b0);
        wait_done(40, n);
        chk("mul2_latency", n, 32);
        chk("mul2_value", bus.value, 32'd15);
        chk("mul2_value_hi", bus.value_hi, 32'd0);
        chk("mul2_flags", flags(), 4'b0000);

`ifdef ALU_DIV_EN
        issue(4'd11, 32'd100, 32'd7);
        chk("div_busy", bus.busy, 1'b1);
        wait_done(40, n);
        chk("div_latency", n, 32);
        chk("div_value", bus.value, 32'd14);
        chk("div_value_hi", bus.value_hi, 32'd2);
        chk("div_flags", flags(), 4'b0000);
        issue(4'd11, 32'd5, 32'd0);
        wait_done(40, n);
        chk("div0_latency", n, 32);
        chk("div0_value", bus.value, 32'hFFFF_FFFF);
        chk("div0_value_hi", bus.value_hi, 32'd5);
        chk("div0_flags", flags(), 4'b1010);
`else
        issue(4'd11, 32'd100, 32'd7);
        chk("op11_done", bus.done, 1'b1);
        chk("op11_busy", bus.busy, 1'b0);
        chk("op11_value", bus.value, 32'd0);
        chk("op11_value_hi", bus.value_hi, 32'd0);
        chk("op11_flags", flags(), 4'b0100);
`endif
        issue(4'd13, 32'd9, 32'd9);
        chk("op13_value", bus.value, 32'd0);
        chk("op13_flags", flags(), 4'b0100);

        // reset during MUL iteration 10
        issue(4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("pre_rst_value", bus.value, 32'hFFFF_FFFE);
        issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_done", bus.done, 1'b0);
        chk("mid_rst_value", bus.value, 32'h0);
        chk("mid_rst_value_hi", bus.value_hi, 32'h0);
        chk("mid_rst_flags", flags(), 4'b0000);
        done_seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        @(negedge clk); rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) done_seen++;
        end
        chk("no_done_after_rst", done_seen, 0);
        issue(4'd0, 32'd1, 32'd2);
        chk("post_rst_done", bus.done, 1'b1);
        chk("post_rst_value", bus.value, 32'd3);
        chk("post_rst_flags", flags(), 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
